// File: rtl/mvm_host.sv
// Host-side sequencer for a matrix-vector accelerator: buffers A (row-major) and x,
// streams them out after a start pulse, captures the N results and drains them.
module mvm_host #(
  parameter int MAT_SCALE    = 3,
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 16,
  parameter int OUT_OFFSET   = 1,
  parameter int TIMEOUT      = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [INPUT_WIDTH-1:0]  in_data,
  output logic                           acc_start,
  output logic signed [INPUT_WIDTH-1:0]  acc_data_in,
  input  logic                           acc_done,
  input  logic signed [OUTPUT_WIDTH-1:0] acc_data_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUTPUT_WIDTH-1:0] out_data,
  output logic                           out_last,
  output logic                           busy,
  output logic                           timeout_err
);
  localparam int N      = MAT_SCALE;
  localparam int BUF_SZ = N * N + N;
  localparam int BW     = (BUF_SZ > 1) ? $clog2(BUF_SZ) : 1;
  localparam int RW     = (N > 1) ? $clog2(N) : 1;
  localparam int WW     = $clog2(TIMEOUT + 1);
  localparam int DLY    = (OUT_OFFSET > 0) ? OUT_OFFSET - 1 : 0;
  localparam int DW     = (DLY > 0) ? $clog2(DLY + 1) : 1;

  localparam logic [BW-1:0] BUF_LAST  = BW'(BUF_SZ - 1);
  localparam logic [RW-1:0] RES_LAST  = RW'(N - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {LOAD, START, STREAM, WAIT, CAPTURE, DRAIN} state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic [BW-1:0]                  r_widx;
  logic [BW-1:0]                  r_ridx;
  logic [WW-1:0]                  r_wcnt;
  logic [DW-1:0]                  r_dcnt;
  logic [RW-1:0]                  r_kidx;
  logic [RW-1:0]                  r_oidx;
  logic                           r_terr;
  logic signed [INPUT_WIDTH-1:0]  r_buf [BUF_SZ];
  logic signed [OUTPUT_WIDTH-1:0] r_res [N];

  logic w_in_fire;
  logic w_out_fire;
  logic w_timeout;
  logic w_cap;

  always_comb begin
    w_next      = r_state;
    w_in_fire   = 1'b0;
    w_out_fire  = 1'b0;
    w_timeout   = 1'b0;
    w_cap       = 1'b0;
    in_ready    = 1'b0;
    acc_start   = 1'b0;
    acc_data_in = '0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    busy        = 1'b1;
    case (r_state)
      LOAD: begin
        in_ready  = 1'b1;
        busy      = 1'b0;
        w_in_fire = in_valid;
        if (in_valid && r_widx == BUF_LAST) w_next = START;
      end
      START: begin
        acc_start = 1'b1;
        w_next    = STREAM;
      end
      STREAM: begin
        acc_data_in = r_buf[r_ridx];
        if (r_ridx == BUF_LAST) w_next = WAIT;
      end
      WAIT: begin
        if (acc_done) begin
          w_next = CAPTURE;
          // With zero offset, y[0] is already on the bus in the done cycle.
          if (OUT_OFFSET == 0) begin
            w_cap = 1'b1;
            if (N == 1) w_next = DRAIN;
          end
        end else if (r_wcnt == WAIT_LAST) begin
          w_timeout = 1'b1;
          w_next    = LOAD;
        end
      end
      CAPTURE: begin
        if (r_dcnt == '0) begin
          w_cap = 1'b1;
          if (r_kidx == RES_LAST) w_next = DRAIN;
        end
      end
      DRAIN: begin
        out_valid  = 1'b1;
        out_data   = r_res[r_oidx];
        out_last   = (r_oidx == RES_LAST);
        w_out_fire = out_ready;
        if (out_ready && out_last) w_next = LOAD;
      end
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD;
      r_widx  <= '0;
      r_ridx  <= '0;
      r_wcnt  <= '0;
      r_dcnt  <= '0;
      r_kidx  <= '0;
      r_oidx  <= '0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_timeout)
        r_widx <= '0;
      else if (w_in_fire)
        r_widx <= (r_widx == BUF_LAST) ? '0 : r_widx + 1'b1;
      if (r_state == STREAM)
        r_ridx <= (r_ridx == BUF_LAST) ? '0 : r_ridx + 1'b1;
      r_wcnt <= (r_state == WAIT && w_next == WAIT) ? r_wcnt + 1'b1 : '0;
      // Delay counter is armed every WAIT cycle so it is ready when done arrives.
      if (r_state == WAIT)
        r_dcnt <= DW'(DLY);
      else if (r_state == CAPTURE && r_dcnt != '0)
        r_dcnt <= r_dcnt - 1'b1;
      if (w_cap)
        r_kidx <= (r_kidx == RES_LAST) ? '0 : r_kidx + 1'b1;
      if (w_out_fire)
        r_oidx <= (r_oidx == RES_LAST) ? '0 : r_oidx + 1'b1;
      if (w_timeout)
        r_terr <= 1'b1;
      else if (w_in_fire)
        r_terr <= 1'b0;
    end
  end

  // Element and result storage carries no reset; only the indices do.
  always_ff @(posedge clk) begin
    if (w_in_fire) r_buf[r_widx] <= in_data;
    if (w_cap)     r_res[r_kidx] <= acc_data_out;
  end

  assign timeout_err = r_terr;

endmodule

// File: tb/tb_mvm_host.sv
// Bench for mvm_host: a behavioural accelerator answers each job, and expected
// results are predicted as y = A*x directly from the elements sent upstream.
module tb_mvm_host;
  localparam int N   = 3;
  localparam int IW  = 8;
  localparam int OW  = 16;
  localparam int OFS = 1;
  localparam int TO  = 64;
  localparam int BUF = N * N + N;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  out_ready = 1'b0;
  logic signed [IW-1:0]  in_data = '0;
  logic                  in_ready, acc_start, out_valid, out_last, busy, timeout_err;
  logic signed [IW-1:0]  acc_data_in;
  logic                  acc_done;
  logic                  acc_done_m = 1'b0;
  logic                  spur_done = 1'b0;
  logic signed [OW-1:0]  acc_data_out = '0;
  logic signed [OW-1:0]  out_data;

  assign acc_done = acc_done_m | spur_done;
  always #5 clk = ~clk;

  mvm_host #(.MAT_SCALE(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
             .OUT_OFFSET(OFS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .acc_start(acc_start), .acc_data_in(acc_data_in),
    .acc_done(acc_done), .acc_data_out(acc_data_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .timeout_err(timeout_err));

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  bit acc_no_done = 1'b0;
  int acc_lat = 3;
  logic signed [IW-1:0] elems [BUF];
  logic signed [IW-1:0] acc_rx [BUF];
  logic signed [OW-1:0] acc_y [N];
  logic signed [OW-1:0] exp_y [N];
  logic signed [OW-1:0] got_y [N];
  logic [N-1:0]         got_last;
  logic signed [OW-1:0] stall_val;
  bit drain_stable, drain_to;

  always @(negedge clk) if (acc_start === 1'b1) start_cnt++;

  // Accelerator: collect the stream after start, then pulse done and present y.
  initial begin
    forever begin
      @(negedge clk);
      if (acc_start === 1'b1) begin
        for (int i = 0; i < BUF; i++) begin
          @(negedge clk);
          acc_rx[i] = acc_data_in;
        end
        for (int r = 0; r < N; r++) begin
          int s;
          s = 0;
          for (int c = 0; c < N; c++) s += int'(acc_rx[r*N+c]) * int'(acc_rx[N*N+c]);
          acc_y[r] = OW'(s);
        end
        if (!acc_no_done) begin
          repeat (acc_lat) @(negedge clk);
          acc_done_m = 1'b1;
          acc_data_out = OW'($urandom);
          @(negedge clk);
          acc_done_m = 1'b0;
          repeat (OFS - 1) begin
            acc_data_out = OW'($urandom);
            @(negedge clk);
          end
          for (int k = 0; k < N; k++) begin
            acc_data_out = acc_y[k];
            @(negedge clk);
          end
          acc_data_out = OW'($urandom);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void predict();
    for (int r = 0; r < N; r++) begin
      int s;
      s = 0;
      for (int c = 0; c < N; c++) s += int'(elems[r*N+c]) * int'(elems[N*N+c]);
      exp_y[r] = OW'(s);
    end
  endfunction

  function automatic void rand_elems();
    for (int i = 0; i < BUF; i++) elems[i] = IW'($urandom);
  endfunction

  function automatic void basic_elems();
    for (int i = 0; i < N * N; i++) elems[i] = IW'(i + 1);
    for (int i = 0; i < N; i++) elems[N*N+i] = IW'(i + 1);
  endfunction

  task automatic load_job(input int first, input int upto, input bit toggle, output bit ok);
    int idx;
    int cyc;
    idx = first;
    cyc = 0;
    while (idx < upto && cyc < 100) begin
      in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      in_data  = elems[idx];
      if (in_valid && in_ready) idx++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    ok = (idx >= upto);
  endtask

  task automatic drain(input int stall, input bit rnd_ready);
    int j;
    int cyc;
    bit pend;
    logic signed [OW-1:0] held;
    j = 0; cyc = 0; pend = 0; held = '0;
    drain_stable = 1'b1; drain_to = 1'b0; got_last = '0; out_ready = 1'b0;
    while (out_valid !== 1'b1 && cyc < 300) begin step(); cyc++; end
    if (out_valid !== 1'b1) begin drain_to = 1'b1; return; end
    stall_val = out_data;
    repeat (stall) begin
      step();
      if (out_valid !== 1'b1 || out_data !== stall_val) drain_stable = 1'b0;
    end
    while (j < N && cyc < 300) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid === 1'b1) begin
        if (pend && out_data !== held) drain_stable = 1'b0;
        if (out_ready) begin
          got_y[j] = out_data; got_last[j] = out_last; j++; pend = 1'b0;
        end else begin
          pend = 1'b1; held = out_data;
        end
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    if (j < N) drain_to = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, acc_start, out_valid, out_last, busy, timeout_err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 100000",
               {in_ready, acc_start, out_valid, out_last, busy, timeout_err});
    end
    checks++;
    if (acc_data_in !== '0) begin errors++; $display("FAIL reset_acc_data_in got %0d expected 0", acc_data_in); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0d expected 0", out_data); end
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    int s0;
    basic_elems();
    exp_y[0] = 16'sd14; exp_y[1] = 16'sd32; exp_y[2] = 16'sd50;
    acc_lat = 3;
    s0 = start_cnt;
    load_job(0, BUF, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_load got timeout expected accepted"); end
    drain(0, 1'b0);
    checks++; if (drain_to) begin errors++; $display("FAIL basic_drain got timeout expected %0d results", N); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_y[k] !== exp_y[k]) begin errors++; $display("FAIL basic_y%0d got %0d expected %0d", k, got_y[k], exp_y[k]); end
    end
    checks++; if (got_last !== 3'b100) begin errors++; $display("FAIL basic_last got %b expected 100", got_last); end
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL basic_post got %b expected 01", {out_valid, in_ready}); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL basic_starts got %0d expected 1", start_cnt - s0); end
    for (int i = 0; i < BUF; i++) begin
      checks++;
      if (acc_rx[i] !== elems[i]) begin errors++; $display("FAIL basic_stream%0d got %0d expected %0d", i, acc_rx[i], elems[i]); end
    end
  endtask

  task automatic test_toggle_load();
    bit ok;
    rand_elems(); predict();
    acc_lat = $urandom_range(1, 20);
    checks++; if (acc_data_in !== '0) begin errors++; $display("FAIL toggle_idle_data got %0d expected 0", acc_data_in); end
    load_job(0, BUF, 1'b1, ok);
    checks++;
    if (!ok || {acc_start, in_ready} !== 2'b10) begin
      errors++; $display("FAIL toggle_start got ok=%0d start/ready=%b expected ok=1 10", ok, {acc_start, in_ready});
    end
    drain(0, 1'b1);
    checks++; if (drain_to || !drain_stable) begin errors++; $display("FAIL toggle_drain got to=%0d stable=%0d expected 0 1", drain_to, drain_stable); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_y[k] !== exp_y[k]) begin errors++; $display("FAIL toggle_y%0d got %0d expected %0d", k, got_y[k], exp_y[k]); end
    end
    for (int i = 0; i < BUF; i++) begin
      checks++;
      if (acc_rx[i] !== elems[i]) begin errors++; $display("FAIL toggle_stream%0d got %0d expected %0d", i, acc_rx[i], elems[i]); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    basic_elems(); predict();
    acc_lat = 5;
    load_job(0, BUF, 1'b0, ok);
    drain(5, 1'b0);
    checks++; if (stall_val !== 16'sd14) begin errors++; $display("FAIL stall_hold got %0d expected 14", stall_val); end
    checks++; if (drain_to || !drain_stable) begin errors++; $display("FAIL stall_stable got to=%0d stable=%0d expected 0 1", drain_to, drain_stable); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_y[k] !== exp_y[k]) begin errors++; $display("FAIL stall_y%0d got %0d expected %0d", k, got_y[k], exp_y[k]); end
    end
    checks++; if (got_last !== 3'b100) begin errors++; $display("FAIL stall_last got %b expected 100", got_last); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_extra got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc;
    rand_elems(); predict();
    acc_no_done = 1'b1;
    load_job(0, BUF, 1'b0, ok);
    cyc = 0;
    while (busy === 1'b1 && cyc < 300) begin step(); cyc++; end
    checks++; if (cyc !== 1 + BUF + TO) begin errors++; $display("FAIL timeout_cycles got %0d expected %0d", cyc, 1 + BUF + TO); end
    checks++;
    if ({timeout_err, busy, in_ready} !== 3'b101) begin
      errors++; $display("FAIL timeout_flags got %b expected 101", {timeout_err, busy, in_ready});
    end
    acc_no_done = 1'b0;
    acc_lat = $urandom_range(1, 20);
    step();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b expected 1", timeout_err); end
    in_valid = 1'b1; in_data = elems[0];
    step();
    in_valid = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b expected 0", timeout_err); end
    load_job(1, BUF, 1'b0, ok);
    drain(0, 1'b0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_y[k] !== exp_y[k]) begin errors++; $display("FAIL timeout_y%0d got %0d expected %0d", k, got_y[k], exp_y[k]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int s0;
    rand_elems();
    acc_lat = $urandom_range(1, 20);
    load_job(0, BUF, 1'b0, ok);
    step(); step(); step();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, acc_start, out_valid, out_last, busy, timeout_err} !== 6'b100000) begin
      errors++;
      $display("FAIL midrst_ctrl got %b expected 100000",
               {in_ready, acc_start, out_valid, out_last, busy, timeout_err});
    end
    checks++; if (acc_data_in !== '0) begin errors++; $display("FAIL midrst_data got %0d expected 0", acc_data_in); end
    @(posedge clk); #1;
    reset = 1'b1;
    s0 = start_cnt; seen = 1'b0;
    repeat (50) begin step(); if (out_valid !== 1'b0) seen = 1'b1; end
    rand_elems(); predict();
    load_job(0, 5, 1'b0, ok);
    repeat (10) begin step(); if (out_valid !== 1'b0) seen = 1'b1; end
    checks++;
    if (start_cnt != s0 || seen || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_idle got starts=%0d out=%0d busy=%b expected 0 0 0", start_cnt - s0, seen, busy);
    end
    load_job(5, BUF, 1'b0, ok);
    drain(0, 1'b1);
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL midrst_starts got %0d expected 1", start_cnt - s0); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_y[k] !== exp_y[k]) begin errors++; $display("FAIL midrst_y%0d got %0d expected %0d", k, got_y[k], exp_y[k]); end
    end
  endtask

  task automatic test_spurious();
    bit ok;
    int s0;
    rand_elems(); predict();
    acc_lat = 15;
    s0 = start_cnt;
    fork
      load_job(0, BUF, 1'b1, ok);
      begin repeat (4) step(); spur_done = 1'b1; step(); spur_done = 1'b0; end
    join
    step(); step(); step(); step();
    spur_done = 1'b1; step(); spur_done = 1'b0;
    drain(0, 1'b0);
    checks++; if (drain_to) begin errors++; $display("FAIL spur_drain got timeout expected %0d results", N); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_y[k] !== exp_y[k]) begin errors++; $display("FAIL spur_y%0d got %0d expected %0d", k, got_y[k], exp_y[k]); end
    end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL spur_starts got %0d expected 1", start_cnt - s0); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int job = 0; job < 3; job++) begin
      rand_elems(); predict();
      acc_lat = $urandom_range(1, 20);
      load_job(0, BUF, 1'($urandom_range(0, 1)), ok);
      drain(0, 1'b1);
      checks++; if (drain_to || !drain_stable) begin errors++; $display("FAIL b2b%0d_drain got to=%0d stable=%0d expected 0 1", job, drain_to, drain_stable); end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (got_y[k] !== exp_y[k]) begin errors++; $display("FAIL b2b%0d_y%0d got %0d expected %0d", job, k, got_y[k], exp_y[k]); end
      end
      checks++; if (got_last !== 3'b100) begin errors++; $display("FAIL b2b%0d_last got %b expected 100", job, got_last); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle_load();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_spurious();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
